// File: rtl/alu_issue_scheduler_if.sv
// Bundled reservation-station, ALU and CDB signals of the ALU issue scheduler.
// master = scheduler side, slave = surrounding environment (RS array, ALU, CDB arbiter).
interface alu_issue_scheduler_if #(
  parameter int unsigned NUM_RS = 5,
  parameter int unsigned TAG_W  = 3
);
  logic [NUM_RS-1:0]       rs_ready;
  logic [NUM_RS*32-1:0]    rs_src1;
  logic [NUM_RS*32-1:0]    rs_src2;
  logic [NUM_RS*3-1:0]     rs_funct3;
  logic [NUM_RS-1:0]       rs_funct7;
  logic [NUM_RS-1:0]       rs_arith;
  logic [NUM_RS*TAG_W-1:0] rs_tag;
  logic [NUM_RS-1:0]       rs_ack;

  logic [31:0]             alu_src1;
  logic [31:0]             alu_src2;
  logic [2:0]              alu_funct3;
  logic                    alu_funct7;
  logic                    alu_arith;
  logic [31:0]             alu_result;

  logic                    cdb_req;
  logic [TAG_W-1:0]        cdb_tag;
  logic [31:0]             cdb_data;
  logic                    cdb_grant;

  modport master (
    input  rs_ready, rs_src1, rs_src2, rs_funct3, rs_funct7, rs_arith, rs_tag,
    input  alu_result, cdb_grant,
    output rs_ack, alu_src1, alu_src2, alu_funct3, alu_funct7, alu_arith,
    output cdb_req, cdb_tag, cdb_data
  );

  modport slave (
    output rs_ready, rs_src1, rs_src2, rs_funct3, rs_funct7, rs_arith, rs_tag,
    output alu_result, cdb_grant,
    input  rs_ack, alu_src1, alu_src2, alu_funct3, alu_funct7, alu_arith,
    input  cdb_req, cdb_tag, cdb_data
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of ready RS entries into a shared ALU with a one-entry CDB output register.
// Optional ALU_STATS_EN adds saturating issue/stall counters.
module alu_issue_scheduler #(
  parameter int unsigned NUM_RS = 5,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  alu_issue_scheduler_if.master bus
`ifdef ALU_STATS_EN
  ,
  output logic [31:0]         stat_issued_o,
  output logic [31:0]         stat_stall_o
`endif
);

  localparam int unsigned PtrW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [31:0]        data_q, data_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [PtrW-1:0]    sel;
  logic               any_ready;
  logic               drive_en;
  logic               can_issue;
  logic               issue;
  logic [TAG_W-1:0]   sel_tag;
  int unsigned        idx;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_RS) idx = idx - NUM_RS;
      if (!any_ready && bus.rs_ready[PtrW'(idx)]) begin
        any_ready = 1'b1;
        sel       = PtrW'(idx);
      end
    end
  end

  // Reset also forces the ALU drive and acks low, since they are combinational.
  assign drive_en  = any_ready && rst_ni;
  assign can_issue = rst_ni && !flush_i && ((state_q == StEmpty) || bus.cdb_grant);
  assign issue     = can_issue && any_ready;

  always_comb begin
    bus.alu_src1   = '0;
    bus.alu_src2   = '0;
    bus.alu_funct3 = '0;
    bus.alu_funct7 = 1'b0;
    bus.alu_arith  = 1'b0;
    bus.rs_ack     = '0;
    sel_tag        = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (drive_en && (sel == PtrW'(i))) begin
        bus.alu_src1   = bus.rs_src1[32*i +: 32];
        bus.alu_src2   = bus.rs_src2[32*i +: 32];
        bus.alu_funct3 = bus.rs_funct3[3*i +: 3];
        bus.alu_funct7 = bus.rs_funct7[i];
        bus.alu_arith  = bus.rs_arith[i];
        sel_tag        = bus.rs_tag[TAG_W*i +: TAG_W];
        bus.rs_ack[i]  = issue;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StEmpty: if (issue) state_d = StFull;
      StFull: begin
        if (flush_i) begin
          state_d = StEmpty;
        end else if (bus.cdb_grant && !issue) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (issue) begin
      data_d = bus.alu_result;
      tag_d  = sel_tag;
      ptr_d  = (sel == PtrW'(NUM_RS - 1)) ? '0 : sel + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      data_q  <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.cdb_req  = (state_q == StFull);
  assign bus.cdb_data = data_q;
  assign bus.cdb_tag  = tag_q;

`ifdef ALU_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (issue && (issued_q != '1)) issued_d = issued_q + 32'd1;
    if (any_ready && !can_issue && !flush_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued_o = issued_q;
  assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed and random stimulus for alu_issue_scheduler against a queue-free behavioural model.
module tb_alu_issue_scheduler;
  localparam int N  = 5;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  alu_issue_scheduler_if #(.NUM_RS(N), .TAG_W(TW)) bus ();

`ifdef ALU_STATS_EN
  logic [31:0] stat_issued, stat_stall;
  alu_issue_scheduler #(.NUM_RS(N), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus),
    .stat_issued_o(stat_issued), .stat_stall_o(stat_stall)
  );
`else
  alu_issue_scheduler #(.NUM_RS(N), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic f7, input logic ar);
    if (!ar) return a + b;
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Combinational ALU seen by the scheduler.
  always_comb bus.alu_result = alu_fn(bus.alu_src1, bus.alu_src2, bus.alu_funct3,
                                      bus.alu_funct7, bus.alu_arith);

  // Reference model state.
  int          m_ptr;
  bit          m_full;
  logic [31:0] m_data;
  logic [TW-1:0] m_tag;
  int          m_iss, m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [2:0] f3, input logic f7, input logic ar,
                           input logic [TW-1:0] tg);
    bus.rs_src1[32*i +: 32]  = s1;
    bus.rs_src2[32*i +: 32]  = s2;
    bus.rs_funct3[3*i +: 3]  = f3;
    bus.rs_funct7[i]         = f7;
    bus.rs_arith[i]          = ar;
    bus.rs_tag[TW*i +: TW]   = tg;
  endtask

  task automatic rand_entries();
    for (int i = 0; i < N; i++)
      set_entry(i, $urandom, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), TW'($urandom));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_tag = '0; m_iss = 0; m_stall = 0;
  endtask

  function automatic logic [31:0] entry_result(input int s);
    return alu_fn(bus.rs_src1[32*s +: 32], bus.rs_src2[32*s +: 32], bus.rs_funct3[3*s +: 3],
                  bus.rs_funct7[s], bus.rs_arith[s]);
  endfunction

  // Called just after a falling edge with inputs applied; checks then advances one cycle.
  task automatic step();
    bit any = 0;
    int s = 0;
    bit can, iss;
    logic [N-1:0] e_ack = '0;
    #1;
    chk("cdb_req", 32'(bus.cdb_req), 32'(m_full));
    if (m_full) begin
      chk("cdb_data", bus.cdb_data, m_data);
      chk("cdb_tag", 32'(bus.cdb_tag), 32'(m_tag));
    end
`ifdef ALU_STATS_EN
    chk("stat_issued", stat_issued, 32'(m_iss));
    chk("stat_stall", stat_stall, 32'(m_stall));
`endif
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (!any && bus.rs_ready[j]) begin any = 1; s = j; end
    end
    can = !flush && (!m_full || bus.cdb_grant);
    iss = can && any;
    if (iss) e_ack[s] = 1'b1;
    chk("rs_ack", 32'(bus.rs_ack), 32'(e_ack));
    chk("alu_src1", bus.alu_src1, any ? bus.rs_src1[32*s +: 32] : 32'd0);
    chk("alu_src2", bus.alu_src2, any ? bus.rs_src2[32*s +: 32] : 32'd0);
    chk("alu_ctrl", 32'({bus.alu_funct3, bus.alu_funct7, bus.alu_arith}),
        any ? 32'({bus.rs_funct3[3*s +: 3], bus.rs_funct7[s], bus.rs_arith[s]}) : 32'd0);
    @(posedge clk);
    if (any && !can && !flush) m_stall++;
    if (flush) m_full = 0;
    else if (iss) begin
      m_full = 1;
      m_data = entry_result(s);
      m_tag  = bus.rs_tag[TW*s +: TW];
    end else if (m_full && bus.cdb_grant) m_full = 0;
    if (iss) begin
      m_ptr = (s + 1) % N;
      m_iss++;
    end
    @(negedge clk);
  endtask

  logic [31:0] exp_res;

  initial begin
    bus.rs_ready = '0; bus.cdb_grant = 1'b0;
    bus.rs_src1 = '0; bus.rs_src2 = '0; bus.rs_funct3 = '0;
    bus.rs_funct7 = '0; bus.rs_arith = '0; bus.rs_tag = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.cdb_req), 32'd0);
    chk("rst_data", bus.cdb_data, 32'd0);
    chk("rst_tag", 32'(bus.cdb_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with constant grant.
    for (int i = 0; i < N; i++)
      set_entry(i, $urandom, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), TW'(i + 1));
    bus.rs_ready = 5'b11111; bus.cdb_grant = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ack", 32'(bus.rs_ack), 32'd1 << (k % N));
      if (k > 0) chk("rr_tag", 32'(bus.cdb_tag), 32'(((k - 1) % N) + 1));
      step();
    end

    // Data path: entry 2 only, arith sub.
    bus.rs_ready = 5'b00100;
    set_entry(2, 32'h0000_0010, 32'h0000_0003, 3'd0, 1'b1, 1'b1, TW'(3));
    step();
    #1;
    chk("dp_req", 32'(bus.cdb_req), 32'd1);
    chk("dp_data", bus.cdb_data, 32'h0000_000D);
    chk("dp_tag", 32'(bus.cdb_tag), 32'd3);

    // Backpressure with entries 0 and 1 ready.
    bus.rs_ready = 5'b00011; bus.cdb_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ack", 32'(bus.rs_ack), 32'd0);
      chk("bp_data", bus.cdb_data, 32'h0000_000D);
      step();
    end
    bus.cdb_grant = 1'b1;
    exp_res = entry_result(0);
    #1 chk("bp_grant_ack", 32'(bus.rs_ack), 32'd1);
    step();
    #1 chk("bp_new_data", bus.cdb_data, exp_res);

    // Flush with entry 3 ready and no grant.
    bus.rs_ready = 5'b01000; bus.cdb_grant = 1'b0; flush = 1'b1;
    #1 chk("fl_ack", 32'(bus.rs_ack), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_req", 32'(bus.cdb_req), 32'd0);
    chk("fl_next_ack", 32'(bus.rs_ack), 32'b01000);
    step();

    // Asynchronous reset while a result is pending.
    bus.rs_ready = 5'b11111; bus.cdb_grant = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.cdb_req), 32'd0);
    chk("ar_data", bus.cdb_data, 32'd0);
    chk("ar_tag", 32'(bus.cdb_tag), 32'd0);
    chk("ar_ack", 32'(bus.rs_ack), 32'd0);
    model_reset();
    @(posedge clk);
    #1 chk("ar_hold_req", 32'(bus.cdb_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.cdb_grant = 1'b1;
    #1 chk("ar_first_ack", 32'(bus.rs_ack), 32'd1);
    step();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rand_entries();
      bus.rs_ready  = N'($urandom);
      bus.cdb_grant = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    step();

`ifdef ALU_STATS_EN
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rs_ready = 5'b11111; bus.cdb_grant = 1'b1;
    for (int k = 0; k < 3; k++) step();
    bus.cdb_grant = 1'b0;
    for (int k = 0; k < 2; k++) step();
    #1;
    chk("st_issued", stat_issued, 32'd3);
    chk("st_stall", stat_stall, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
